// File: rtl/cache_pkg.sv
// Widths, FSM states and block/address layout shared by the cache and its miss handler.
// Addresses are {tag, index, word}; blocks are {word1, word0}.
package cache_pkg;
  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 8;
  localparam int IDX_W     = 2;
  localparam int TAG_W     = ADDR_W - IDX_W - 1;
  localparam int BLK_W     = 2 * DATA_W;
  localparam int WORD0_LSB = 0;
  localparam int WORD1_LSB = DATA_W;
  localparam int WORD_BIT  = 0;
  localparam int IDX_LSB   = 1;
  localparam int TAG_LSB   = IDX_W + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WB0  = 3'd1,
    WB1  = 3'd2,
    RD0  = 3'd3,
    RD1  = 3'd4,
    FILL = 3'd5
  } state_e;

  function automatic logic [ADDR_W-1:0] make_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic             word);
    return {tag, idx, word};
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: registered, one cycle from inc to count; sticks at all-ones.
// No backpressure; inc is accepted every cycle.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/cache_miss_handler.sv
// Miss handler: writes back a dirty victim, reads the missing block, returns one fill beat.
// Zero-wait latency 3 (clean) / 5 (dirty) cycles; each mem_ack wait cycle stalls the FSM by one.
module cache_miss_handler
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              miss_we,
  input  logic [DATA_W-1:0] miss_wdata,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [BLK_W-1:0]  victim_data,
  output logic              miss_ack,
  output logic              fill_valid,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [IDX_W-1:0]  fill_index,
  output logic [BLK_W-1:0]  fill_data,
  output logic              fill_dirty,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  wb_count
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
  logic [BLK_W-1:0]  vic_data_q, vic_data_d;
  logic [DATA_W-1:0] rd_word0_q, rd_word0_d;
  logic [TAG_W-1:0]  fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]  fill_index_q, fill_index_d;
  logic [BLK_W-1:0]  fill_data_q, fill_data_d;
  logic              fill_dirty_q, fill_dirty_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLK_W-1:0]  blk;
  logic [IDX_W-1:0]  idx_nxt;
  logic              miss_inc, wb_inc;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    vic_tag_d    = vic_tag_q;
    vic_data_d   = vic_data_q;
    rd_word0_d   = rd_word0_q;
    fill_tag_d   = fill_tag_q;
    fill_index_d = fill_index_q;
    fill_data_d  = fill_data_q;
    fill_dirty_d = fill_dirty_q;
    blk          = '0;
    miss_inc     = 1'b0;
    wb_inc       = 1'b0;

    case (state_q)
      IDLE: if (miss_req) begin
        req_addr_d  = miss_addr;
        req_we_d    = miss_we;
        req_wdata_d = miss_wdata;
        vic_tag_d   = victim_tag;
        vic_data_d  = victim_data;
        miss_inc    = 1'b1;
        state_d     = (victim_valid && victim_dirty) ? WB0 : RD0;
      end
      WB0: if (mem_ack) state_d = WB1;
      WB1: if (mem_ack) begin
        wb_inc  = 1'b1;
        state_d = RD0;
      end
      RD0: if (mem_ack) begin
        rd_word0_d = mem_rdata;
        state_d    = RD1;
      end
      RD1: if (mem_ack) begin
        // Word0 is staged separately so the visible fill_data only changes at a fill.
        blk = {mem_rdata, rd_word0_q};
        if (req_we_q) begin
          if (req_addr_q[WORD_BIT]) blk[WORD1_LSB +: DATA_W] = req_wdata_q;
          else                      blk[WORD0_LSB +: DATA_W] = req_wdata_q;
        end
        fill_data_d  = blk;
        fill_tag_d   = req_addr_q[TAG_LSB +: TAG_W];
        fill_index_d = req_addr_q[IDX_LSB +: IDX_W];
        fill_dirty_d = req_we_q;
        state_d      = FILL;
      end
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    idx_nxt     = req_addr_d[IDX_LSB +: IDX_W];
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    case (state_d)
      WB0: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = make_addr(vic_tag_d, idx_nxt, 1'b0);
        mem_wdata_d = vic_data_d[WORD0_LSB +: DATA_W];
      end
      WB1: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = make_addr(vic_tag_d, idx_nxt, 1'b1);
        mem_wdata_d = vic_data_d[WORD1_LSB +: DATA_W];
      end
      RD0: begin
        mem_req_d  = 1'b1;
        mem_addr_d = make_addr(req_addr_d[TAG_LSB +: TAG_W], idx_nxt, 1'b0);
      end
      RD1: begin
        mem_req_d  = 1'b1;
        mem_addr_d = make_addr(req_addr_d[TAG_LSB +: TAG_W], idx_nxt, 1'b1);
      end
      default: ;
    endcase
    ack_d  = (state_d == FILL);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_addr_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      vic_tag_q    <= '0;
      vic_data_q   <= '0;
      rd_word0_q   <= '0;
      fill_tag_q   <= '0;
      fill_index_q <= '0;
      fill_data_q  <= '0;
      fill_dirty_q <= 1'b0;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      vic_tag_q    <= vic_tag_d;
      vic_data_q   <= vic_data_d;
      rd_word0_q   <= rd_word0_d;
      fill_tag_q   <= fill_tag_d;
      fill_index_q <= fill_index_d;
      fill_data_q  <= fill_data_d;
      fill_dirty_q <= fill_dirty_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (.clk(clk), .rst(rst), .inc(miss_inc), .count(miss_count));
  sat_counter #(.CNT_W(CNT_W)) u_wb_cnt   (.clk(clk), .rst(rst), .inc(wb_inc),   .count(wb_count));

  assign miss_ack   = ack_q;
  assign fill_valid = ack_q;
  assign fill_tag   = fill_tag_q;
  assign fill_index = fill_index_q;
  assign fill_data  = fill_data_q;
  assign fill_dirty = fill_dirty_q;
  assign busy       = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler with a behavioural memory (configurable wait states).
// A second instance with 2-bit counters shares all inputs for the saturation case.
module tb_cache_miss_handler;
  import cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        miss_req = 1'b0, miss_we = 1'b0;
  logic [7:0]  miss_addr = '0, miss_wdata = '0;
  logic        victim_valid = 1'b0, victim_dirty = 1'b0;
  logic [4:0]  victim_tag = '0;
  logic [15:0] victim_data = '0;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic        miss_ack, fill_valid, fill_dirty, busy, mem_req, mem_we;
  logic [4:0]  fill_tag;
  logic [1:0]  fill_index;
  logic [15:0] fill_data;
  logic [7:0]  mem_addr, mem_wdata;
  logic [15:0] miss_count, wb_count;

  logic        s_miss_ack, s_fill_valid, s_fill_dirty, s_busy, s_mem_req, s_mem_we;
  logic [4:0]  s_fill_tag;
  logic [1:0]  s_fill_index;
  logic [15:0] s_fill_data;
  logic [7:0]  s_mem_addr, s_mem_wdata;
  logic [1:0]  s_miss_count, s_wb_count;

  cache_miss_handler #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_we(miss_we),
    .miss_wdata(miss_wdata), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data), .miss_ack(miss_ack),
    .fill_valid(fill_valid), .fill_tag(fill_tag), .fill_index(fill_index),
    .fill_data(fill_data), .fill_dirty(fill_dirty), .busy(busy), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .miss_count(miss_count), .wb_count(wb_count));

  cache_miss_handler #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .miss_we(miss_we),
    .miss_wdata(miss_wdata), .victim_valid(victim_valid), .victim_dirty(victim_dirty),
    .victim_tag(victim_tag), .victim_data(victim_data), .miss_ack(s_miss_ack),
    .fill_valid(s_fill_valid), .fill_tag(s_fill_tag), .fill_index(s_fill_index),
    .fill_data(s_fill_data), .fill_dirty(s_fill_dirty), .busy(s_busy), .mem_req(s_mem_req),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .miss_count(s_miss_count), .wb_count(s_wb_count));

  int errors = 0;
  int checks = 0;

  // Behavioural memory: acks after wait_cfg idle request cycles, logs every completed beat.
  logic [7:0] mem [256];
  int   wait_cfg = 0, wcnt = 0, acks_left = 1000;
  bit   idle_pulse = 1'b0;
  int   log_n = 0;
  logic       log_we   [16];
  logic [7:0] log_addr [16];
  logic [7:0] log_dat  [16];

  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wcnt >= wait_cfg && acks_left > 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        acks_left = acks_left - 1;
        if (log_n < 16) begin
          log_we[log_n]   = mem_we;
          log_addr[log_n] = mem_addr;
          log_dat[log_n]  = mem_we ? mem_wdata : mem[mem_addr];
          log_n = log_n + 1;
        end
        wcnt = 0;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
      if (idle_pulse) mem_ack = 1'b1;
    end
  end

  // Presents one miss and waits (bounded) for the fill; lat is edges from acceptance, -1 on timeout.
  task automatic do_miss(input logic [7:0] addr, input logic we, input logic [7:0] wd,
                         input logic vv, input logic vd, input logic [4:0] vt,
                         input logic [15:0] vdat, output int lat);
    @(posedge clk); #1;
    miss_addr = addr; miss_we = we; miss_wdata = wd;
    victim_valid = vv; victim_dirty = vd; victim_tag = vt; victim_data = vdat;
    miss_req = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (fill_valid) begin
        lat = k + 1;
        break;
      end
    end
    miss_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (miss_ack !== 1'b0 || fill_valid !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b/%b expected 0/0", miss_ack, fill_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (miss_count !== 16'd0 || wb_count !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", miss_count, wb_count); end
    checks++; if (fill_data !== 16'h0000) begin errors++; $display("FAIL reset_fill_data: got %h expected 0000", fill_data); end
    rst = 1'b0;
  endtask

  task automatic test_clean_read;
    int lat;
    wait_cfg = 0; acks_left = 1000; log_n = 0;
    mem[8'h2C] = 8'hA0; mem[8'h2D] = 8'hA1;
    do_miss(8'h2D, 1'b0, 8'h00, 1'b1, 1'b0, 5'd9, 16'hDEAD, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL clean_latency: got %0d expected 3", lat); end
    checks++; if (miss_ack !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL clean_ack_busy: got %b/%b expected 1/1", miss_ack, busy); end
    checks++; if (fill_tag !== 5'd5 || fill_index !== 2'd2) begin errors++; $display("FAIL clean_tag_idx: got %0d/%0d expected 5/2", fill_tag, fill_index); end
    checks++; if (fill_data !== 16'hA1A0) begin errors++; $display("FAIL clean_fill_data: got %h expected a1a0", fill_data); end
    checks++; if (fill_dirty !== 1'b0) begin errors++; $display("FAIL clean_fill_dirty: got %b expected 0", fill_dirty); end
    checks++; if (miss_count !== 16'd1 || wb_count !== 16'd0) begin errors++; $display("FAIL clean_counts: got %0d/%0d expected 1/0", miss_count, wb_count); end
    checks++; if (log_n !== 2) begin errors++; $display("FAIL clean_beats: got %0d expected 2", log_n); end
    checks++; if (log_we[0] !== 1'b0 || log_addr[0] !== 8'h2C || log_we[1] !== 1'b0 || log_addr[1] !== 8'h2D)
      begin errors++; $display("FAIL clean_read_addrs: got %b@%h %b@%h expected 0@2c 0@2d", log_we[0], log_addr[0], log_we[1], log_addr[1]); end
  endtask

  task automatic test_dirty_wait;
    int lat;
    wait_cfg = 2; acks_left = 1000; log_n = 0;
    mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    do_miss(8'h12, 1'b0, 8'h00, 1'b1, 1'b1, 5'd3, 16'h5AC3, lat);
    checks++; if (lat !== 13) begin errors++; $display("FAIL dirty_latency: got %0d expected 13", lat); end
    checks++; if (log_n !== 4) begin errors++; $display("FAIL dirty_beats: got %0d expected 4", log_n); end
    checks++; if (log_we[0] !== 1'b1 || log_addr[0] !== 8'h1A || log_dat[0] !== 8'hC3)
      begin errors++; $display("FAIL dirty_wb0: got %b@%h=%h expected 1@1a=c3", log_we[0], log_addr[0], log_dat[0]); end
    checks++; if (log_we[1] !== 1'b1 || log_addr[1] !== 8'h1B || log_dat[1] !== 8'h5A)
      begin errors++; $display("FAIL dirty_wb1: got %b@%h=%h expected 1@1b=5a", log_we[1], log_addr[1], log_dat[1]); end
    checks++; if (log_we[2] !== 1'b0 || log_addr[2] !== 8'h12 || log_we[3] !== 1'b0 || log_addr[3] !== 8'h13)
      begin errors++; $display("FAIL dirty_reads: got %b@%h %b@%h expected 0@12 0@13", log_we[2], log_addr[2], log_we[3], log_addr[3]); end
    checks++; if (fill_data !== 16'h4433 || fill_tag !== 5'd2 || fill_index !== 2'd1)
      begin errors++; $display("FAIL dirty_fill: got %h t%0d i%0d expected 4433 t2 i1", fill_data, fill_tag, fill_index); end
    checks++; if (wb_count !== 16'd1 || miss_count !== 16'd2) begin errors++; $display("FAIL dirty_counts: got wb %0d miss %0d expected 1/2", wb_count, miss_count); end
  endtask

  task automatic test_write_miss;
    int lat;
    wait_cfg = 0; acks_left = 1000; log_n = 0;
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22;
    do_miss(8'h41, 1'b1, 8'h7E, 1'b0, 1'b0, 5'd0, 16'h0000, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_latency: got %0d expected 3", lat); end
    checks++; if (fill_data !== 16'h7E11) begin errors++; $display("FAIL write_merge: got %h expected 7e11", fill_data); end
    checks++; if (fill_dirty !== 1'b1) begin errors++; $display("FAIL write_dirty: got %b expected 1", fill_dirty); end
    checks++; if (fill_tag !== 5'd8 || fill_index !== 2'd0) begin errors++; $display("FAIL write_tag_idx: got %0d/%0d expected 8/0", fill_tag, fill_index); end
    checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL write_miss_count: got %0d expected 3", miss_count); end
  endtask

  task automatic test_reset_midflight;
    int lat, seen;
    wait_cfg = 0; acks_left = 1; log_n = 0;
    @(posedge clk); #1;
    miss_addr = 8'h04; miss_we = 1'b0; victim_valid = 1'b1; victim_dirty = 1'b1;
    victim_tag = 5'd1; victim_data = 16'hBEEF; miss_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h0D || mem_wdata !== 8'hBE)
      begin errors++; $display("FAIL stall_wb1: got req%b we%b %h=%h expected req1 we1 0d=be", mem_req, mem_we, mem_addr, mem_wdata); end
    rst = 1'b1; miss_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got req%b busy%b expected 0/0", mem_req, busy); end
    checks++; if (miss_count !== 16'd0 || wb_count !== 16'd0) begin errors++; $display("FAIL abort_counts: got %0d/%0d expected 0/0", miss_count, wb_count); end
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (miss_ack || fill_valid || mem_req) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d active cycles expected 0", seen); end
    acks_left = 1000;
    mem[8'h04] = 8'h01; mem[8'h05] = 8'h02;
    do_miss(8'h04, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 16'h0000, lat);
    checks++; if (lat !== 3 || fill_data !== 16'h0201) begin errors++; $display("FAIL after_reset_miss: got lat %0d data %h expected 3 0201", lat, fill_data); end
    checks++; if (miss_count !== 16'd1 || wb_count !== 16'd0) begin errors++; $display("FAIL after_reset_counts: got %0d/%0d expected 1/0", miss_count, wb_count); end
  endtask

  task automatic test_invalid_dirty_victim;
    int lat;
    wait_cfg = 0; acks_left = 1000; log_n = 0;
    mem[8'h36] = 8'h66; mem[8'h37] = 8'h77;
    do_miss(8'h37, 1'b0, 8'h00, 1'b0, 1'b1, 5'h1F, 16'hFFFF, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL invalid_latency: got %0d expected 3", lat); end
    checks++; if (log_n !== 2 || log_we[0] !== 1'b0 || log_we[1] !== 1'b0)
      begin errors++; $display("FAIL invalid_no_write: got %0d beats we %b%b expected 2 beats we 00", log_n, log_we[0], log_we[1]); end
    checks++; if (wb_count !== 16'd0 || miss_count !== 16'd2) begin errors++; $display("FAIL invalid_counts: got wb %0d miss %0d expected 0/2", wb_count, miss_count); end
    checks++; if (fill_data !== 16'h7766 || fill_tag !== 5'd6 || fill_index !== 2'd3)
      begin errors++; $display("FAIL invalid_fill: got %h t%0d i%0d expected 7766 t6 i3", fill_data, fill_tag, fill_index); end
  endtask

  task automatic test_saturation_idle_ack;
    int lat, bad;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cfg = 0; acks_left = 1000;
    mem[8'h00] = 8'h0F; mem[8'h01] = 8'hF0;
    for (int n = 0; n < 5; n++) begin
      do_miss(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 16'h0000, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL sat_miss_latency: miss %0d got %0d expected 3", n, lat); end
    end
    checks++; if (s_miss_count !== 2'd3) begin errors++; $display("FAIL sat_miss_count: got %0d expected 3", s_miss_count); end
    checks++; if (miss_count !== 16'd5) begin errors++; $display("FAIL wide_miss_count: got %0d expected 5", miss_count); end
    checks++; if (s_wb_count !== 2'd0) begin errors++; $display("FAIL sat_wb_count: got %0d expected 0", s_wb_count); end
    @(posedge clk); #1;
    idle_pulse = 1'b1;
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (busy || mem_req || miss_ack || fill_valid) bad++;
    end
    idle_pulse = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_ack_ignored: got %0d active cycles expected 0", bad); end
    checks++; if (miss_count !== 16'd5 || fill_data !== 16'hF00F) begin errors++; $display("FAIL idle_ack_state: got %0d %h expected 5 f00f", miss_count, fill_data); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_clean_read();
    test_dirty_wait();
    test_write_miss();
    test_reset_midflight();
    test_invalid_dirty_victim();
    test_saturation_idle_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
